// File: rtl/countdown_scheduler.sv
// Round-robin scheduler sharing one down-counter among N_REQ requesters.
// Optional abort support is enabled by defining COUNTDOWN_SCHED_ABORT_EN.
module countdown_scheduler #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4,
  parameter int IDX_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] load_val,
`ifdef COUNTDOWN_SCHED_ABORT_EN
  input  logic                   abort,
  output logic                   aborted,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner,
  output logic [CNT_W-1:0]       count
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t           state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n;
  logic [IDX_W-1:0] ptr_inc;
  logic [N_REQ-1:0] gnt_n, done_n;
  logic [IDX_W-1:0] owner_n;
  logic [CNT_W-1:0] count_n;
  logic             found;
  logic [IDX_W-1:0] win;
  int               cand;
`ifdef COUNTDOWN_SCHED_ABORT_EN
  logic             aborted_n;
`endif

  assign busy    = (state != IDLE);
  assign ptr_inc = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);

  // First requester at or after the pointer, wrapping past N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    cand  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!found && req[IDX_W'(cand)]) begin
        found = 1'b1;
        win   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    gnt_n     = gnt;
    done_n    = '0;
    owner_n   = owner;
    count_n   = count;
`ifdef COUNTDOWN_SCHED_ABORT_EN
    aborted_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (found) begin
          owner_n      = win;
          gnt_n        = '0;
          gnt_n[win]   = 1'b1;
          count_n      = load_val[int'(win)*CNT_W +: CNT_W];
          state_n      = COUNT;
        end
      end
      COUNT: begin
`ifdef COUNTDOWN_SCHED_ABORT_EN
        if (abort) begin
          state_n   = IDLE;
          gnt_n     = '0;
          count_n   = '0;
          aborted_n = 1'b1;
          ptr_n     = ptr_inc;
        end else
`endif
        if (count == '0) begin
          state_n       = DONE;
          done_n[owner] = 1'b1;
        end else begin
          count_n = count - CNT_W'(1);
        end
      end
      DONE: begin
        gnt_n   = '0;
        ptr_n   = ptr_inc;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      done    <= '0;
      owner   <= '0;
      count   <= '0;
`ifdef COUNTDOWN_SCHED_ABORT_EN
      aborted <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt     <= gnt_n;
      done    <= done_n;
      owner   <= owner_n;
      count   <= count_n;
`ifdef COUNTDOWN_SCHED_ABORT_EN
      aborted <= aborted_n;
`endif
    end
  end

endmodule
